// File: rtl/byte_serial_adder.sv
// Byte-serial adder: one 8-bit lane per clock, result published only when the whole word is done.
// Optional subtraction (A + ~B + 1) is compiled in with `define BYTE_SERIAL_ADDER_SUB_EN.
module byte_serial_adder #(
    parameter int BYTES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef BYTE_SERIAL_ADDER_SUB_EN
    input  logic                 op,
`endif
    input  logic                 start,
    input  logic [8*BYTES-1:0]   dataA,
    input  logic [8*BYTES-1:0]   dataB,
    output logic [8*BYTES-1:0]   dataR,
    output logic                 carry_out,
    output logic                 busy,
    output logic                 done
);

    localparam int W     = 8 * BYTES;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int SH_W  = IDX_W + 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic               start_q;
    logic               start_rise;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       res_q;
    logic [W-1:0]       res_next;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [SH_W-1:0]    sh;
    logic [7:0]         a_lane;
    logic [7:0]         b_lane;
    logic [8:0]         sum9;
    logic               last_lane;
`ifdef BYTE_SERIAL_ADDER_SUB_EN
    logic               sub_q;
`endif

    assign start_rise = start & ~start_q;
    assign last_lane  = (idx == IDX_W'(BYTES - 1));

    always_comb begin
        sh     = {idx, 3'b000};
        a_lane = 8'(a_q >> sh);
        b_lane = 8'(b_q >> sh);
`ifdef BYTE_SERIAL_ADDER_SUB_EN
        if (sub_q) begin
            b_lane = ~b_lane;
        end
`endif
        sum9     = {1'b0, a_lane} + {1'b0, b_lane} + {8'b0, carry};
        // Merge the current lane into the partial result without a variable part-select
        res_next = (res_q & ~(W'(8'hFF) << sh)) | (W'(sum9[7:0]) << sh);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            dataR     <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef BYTE_SERIAL_ADDER_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        a_q   <= dataA;
                        b_q   <= dataB;
                        res_q <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef BYTE_SERIAL_ADDER_SUB_EN
                        sub_q <= op;
                        carry <= op;
`else
                        carry <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    res_q <= res_next;
                    carry <= sum9[8];
                    idx   <= idx + 1'b1;
                    if (last_lane) begin
                        dataR     <= res_next;
                        carry_out <= sum9[8];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Stay here while the request is still held so a level start cannot retrigger
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed self-checking bench for byte_serial_adder (BYTES=4).
module tb_byte_serial_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] dataR;
    logic        carry_out;
    logic        busy;
    logic        done;
`ifdef BYTE_SERIAL_ADDER_SUB_EN
    logic        op = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    byte_serial_adder #(.BYTES(4)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef BYTE_SERIAL_ADDER_SUB_EN
        .op        (op),
`endif
        .start     (start),
        .dataA     (dataA),
        .dataB     (dataB),
        .dataR     (dataR),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if (busy === 1'b1 && done === 1'b1) begin
                errors++;
                $display("FAIL busy_done_exclusive: busy=%b done=%b, required not both 1", busy, done);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives a start edge and returns the number of edges until done (-1 on timeout)
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        dataA = a;
        dataB = b;
        start = 1'b1;
        lat   = -1;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        reset = 1'b1;
        start = 1'b1;
        dataA = 32'h0000_0001;
        dataB = 32'h0000_0002;
        cycle();
        cycle();
        checks++;
        if ({busy, done, carry_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/carry_out=%b, required 000", {busy, done, carry_out});
        end
        checks++;
        if (dataR !== 32'h0) begin
            errors++;
            $display("FAIL reset_dataR: got %h, required 00000000", dataR);
        end
        // start held high through reset release must count as a rising edge
        reset = 1'b0;
        cycle();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_after_reset: busy=%b, required 1", busy);
        end
        lat = -1;
        for (int i = 2; i <= 30; i++) begin
            cycle();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL reset_op_latency: got %0d edges, required 5", lat);
        end
        checks++;
        if (dataR !== 32'h0000_0003) begin
            errors++;
            $display("FAIL reset_op_result: got %h, required 00000003", dataR);
        end
        start = 1'b0;
        cycle();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_op_release: done=%b, required 0", done);
        end
    endtask

    task automatic test_basic();
        dataA = 32'h1234_5678;
        dataB = 32'h1111_1111;
        start = 1'b1;
        cycle();
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL basic_accept: busy/done=%b, required 10", {busy, done});
        end
        for (int k = 2; k <= 4; k++) begin
            cycle();
            checks++;
            if ({busy, done} !== 2'b10 || dataR !== 32'h0000_0003) begin
                errors++;
                $display("FAIL basic_run_edge%0d: busy/done=%b dataR=%h, required 10 and 00000003", k, {busy, done}, dataR);
            end
        end
        cycle();
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL basic_done: busy/done=%b, required 01", {busy, done});
        end
        checks++;
        if (dataR !== 32'h2345_6789 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: dataR=%h carry_out=%b, required 23456789 0", dataR, carry_out);
        end
        start = 1'b0;
        cycle();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL basic_to_idle: busy/done=%b, required 00", {busy, done});
        end
    endtask

    task automatic test_lane_carry();
        int lat;
        do_op(32'h0000_00FF, 32'h0000_0001, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL lane_carry_latency: got %0d, required 5", lat);
        end
        checks++;
        if (dataR !== 32'h0000_0100 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL lane_carry_result: dataR=%h carry_out=%b, required 00000100 0", dataR, carry_out);
        end
        start = 1'b0;
        cycle();
    endtask

    task automatic test_overflow_hold();
        int lat;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL overflow_latency: got %0d, required 5", lat);
        end
        checks++;
        if (dataR !== 32'h0000_0000 || carry_out !== 1'b1) begin
            errors++;
            $display("FAIL overflow_result: dataR=%h carry_out=%b, required 00000000 1", dataR, carry_out);
        end
        for (int k = 1; k <= 10; k++) begin
            cycle();
            checks++;
            if ({busy, done} !== 2'b01) begin
                errors++;
                $display("FAIL hold_cycle%0d: busy/done=%b, required 01", k, {busy, done});
            end
        end
        start = 1'b0;
        cycle();
        checks++;
        if ({busy, done} !== 2'b00 || dataR !== 32'h0 || carry_out !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: busy/done=%b dataR=%h carry_out=%b, required 00 00000000 1", {busy, done}, dataR, carry_out);
        end
        cycle();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL hold_no_retrigger: busy/done=%b, required 00", {busy, done});
        end
    endtask

    task automatic test_ignore_run();
        int lat;
        dataA = 32'h1234_5678;
        dataB = 32'h1111_1111;
        start = 1'b1;
        cycle();
        cycle();
        dataA = 32'h0;
        dataB = 32'h0;
        start = 1'b0;
        cycle();
        start = 1'b1;
        cycle();
        lat = -1;
        for (int i = 5; i <= 30; i++) begin
            cycle();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL ignore_latency: got %0d, required 5", lat);
        end
        checks++;
        if (dataR !== 32'h2345_6789 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: dataR=%h carry_out=%b, required 23456789 0", dataR, carry_out);
        end
        start = 1'b0;
        cycle();
    endtask

    task automatic test_abort();
        int seen_done;
        dataA = 32'h0000_0001;
        dataB = 32'h0000_0001;
        start = 1'b1;
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        start = 1'b0;
        cycle();
        checks++;
        if ({busy, done, carry_out} !== 3'b000 || dataR !== 32'h0) begin
            errors++;
            $display("FAIL abort_state: busy/done/carry_out=%b dataR=%h, required 000 00000000", {busy, done, carry_out}, dataR);
        end
        reset = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || dataR !== 32'h0) begin
            errors++;
            $display("FAIL abort_no_done: active cycles=%0d dataR=%h, required 0 00000000", seen_done, dataR);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(32'h7FFF_FFFF, 32'h0000_0001, lat);
        checks++;
        if (lat !== 5 || dataR !== 32'h8000_0000 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d dataR=%h carry_out=%b, required 5 80000000 0", lat, dataR, carry_out);
        end
        start = 1'b0;
        cycle();
        do_op(32'h8000_0000, 32'h8000_0000, lat);
        checks++;
        if (lat !== 5 || dataR !== 32'h0 || carry_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d dataR=%h carry_out=%b, required 5 00000000 1", lat, dataR, carry_out);
        end
        start = 1'b0;
        cycle();
    endtask

`ifdef BYTE_SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int lat;
        op = 1'b1;
        do_op(32'h0000_0005, 32'h0000_0007, lat);
        checks++;
        if (lat !== 5 || dataR !== 32'hFFFF_FFFE || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: lat=%0d dataR=%h carry_out=%b, required 5 fffffffe 0", lat, dataR, carry_out);
        end
        start = 1'b0;
        cycle();
        do_op(32'h0000_0007, 32'h0000_0005, lat);
        checks++;
        if (lat !== 5 || dataR !== 32'h0000_0002 || carry_out !== 1'b1) begin
            errors++;
            $display("FAIL sub_no_borrow: lat=%0d dataR=%h carry_out=%b, required 5 00000002 1", lat, dataR, carry_out);
        end
        start = 1'b0;
        op    = 1'b0;
        cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_lane_carry();
        test_overflow_hold();
        test_ignore_run();
        test_abort();
        test_back_to_back();
`ifdef BYTE_SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
